// File: rtl/stopwatch_lap_if.sv
// Control, status and lap-FIFO signals of the stopwatch_lap block.
// The master drives buttons, tick, load and pop; the slave is the stopwatch itself.
interface stopwatch_lap_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH) + 1;

  logic        tick_i;
  logic        btn_start_i;
  logic        btn_lap_i;
  logic        btn_clear_i;
  logic        mode_down_i;
  logic        load_en_i;
  logic [23:0] load_time_i;
  logic        lap_rd_i;
  logic [23:0] time_bcd_o;
  logic        running_o;
  logic        expired_o;
  logic        overflow_o;
  logic        lap_valid_o;
  logic [23:0] lap_data_o;
  logic [CW-1:0] lap_count_o;
  logic        lap_drop_o;

  modport master (
    output tick_i, btn_start_i, btn_lap_i, btn_clear_i, mode_down_i,
           load_en_i, load_time_i, lap_rd_i,
    input  time_bcd_o, running_o, expired_o, overflow_o,
           lap_valid_o, lap_data_o, lap_count_o, lap_drop_o
  );

  modport slave (
    input  tick_i, btn_start_i, btn_lap_i, btn_clear_i, mode_down_i,
           load_en_i, load_time_i, lap_rd_i,
    output time_bcd_o, running_o, expired_o, overflow_o,
           lap_valid_o, lap_data_o, lap_count_o, lap_drop_o
  );
endinterface

// File: rtl/stopwatch_lap.sv
// BCD mm:ss.cc stopwatch / countdown timer with run/pause/done control and a
// show-ahead lap FIFO. Time is kept in BCD so it drives the display directly.
module stopwatch_lap #(
  parameter int LAP_DEPTH = 4,
  parameter int MIN_MAX   = 59,
  parameter int WRAP      = 0
) (
  input  logic clk,
  input  logic rst_n,
  stopwatch_lap_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MM1 = 4'(MIN_MAX / 10);
  localparam logic [3:0] MM0 = 4'(MIN_MAX % 10);
  localparam logic [23:0] TOP = {MM1, MM0, 4'd5, 4'd9, 4'd9, 4'd9};

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] m1, m0, s1, s0, c1, c0;
    {m1, m0, s1, s0, c1, c0} = t;
    if (c0 != 4'd9) c0 = c0 + 4'd1;
    else begin
      c0 = 4'd0;
      if (c1 != 4'd9) c1 = c1 + 4'd1;
      else begin
        c1 = 4'd0;
        if (s0 != 4'd9) s0 = s0 + 4'd1;
        else begin
          s0 = 4'd0;
          if (s1 != 4'd5) s1 = s1 + 4'd1;
          else begin
            s1 = 4'd0;
            if (m0 != 4'd9) m0 = m0 + 4'd1;
            else begin
              m0 = 4'd0;
              m1 = m1 + 4'd1;
            end
          end
        end
      end
    end
    return {m1, m0, s1, s0, c1, c0};
  endfunction

  // Caller guarantees t is non-zero, so the minute borrow never underflows.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [3:0] m1, m0, s1, s0, c1, c0;
    {m1, m0, s1, s0, c1, c0} = t;
    if (c0 != 4'd0) c0 = c0 - 4'd1;
    else begin
      c0 = 4'd9;
      if (c1 != 4'd0) c1 = c1 - 4'd1;
      else begin
        c1 = 4'd9;
        if (s0 != 4'd0) s0 = s0 - 4'd1;
        else begin
          s0 = 4'd9;
          if (s1 != 4'd0) s1 = s1 - 4'd1;
          else begin
            s1 = 4'd5;
            if (m0 != 4'd0) m0 = m0 - 4'd1;
            else begin
              m0 = 4'd9;
              m1 = m1 - 4'd1;
            end
          end
        end
      end
    end
    return {m1, m0, s1, s0, c1, c0};
  endfunction

  // Minutes and seconds clamp as a pair; centisecond digits clamp individually.
  function automatic logic [23:0] clamp_load(input logic [23:0] t);
    logic [3:0] m1, m0, s1, s0, c1, c0;
    {m1, m0, s1, s0, c1, c0} = t;
    if (m1 > 4'd9 || m0 > 4'd9 || {m1, m0} > {MM1, MM0}) {m1, m0} = {MM1, MM0};
    else {m1, m0} = {m1, m0};
    if (s1 > 4'd5 || s0 > 4'd9) {s1, s0} = {4'd5, 4'd9};
    else {s1, s0} = {s1, s0};
    if (c1 > 4'd9) c1 = 4'd9;
    else c1 = c1;
    if (c0 > 4'd9) c0 = 4'd9;
    else c0 = c0;
    return {m1, m0, s1, s0, c1, c0};
  endfunction

  state_t        state_q, state_d;
  logic [23:0]   time_q, time_d, dec_s;
  logic          overflow_q, overflow_d;
  logic          drop_q, drop_d;
  logic          dir_q, dir_d;
  logic          running_q, expired_q;
  logic          btn_start_q, btn_lap_q, btn_clear_q;
  logic [23:0]   fifo_q [LAP_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          start_e_s, lap_e_s, clear_e_s;
  logic          push_s, pop_s, full_s, do_push_s;

  assign start_e_s = bus.btn_start_i & ~btn_start_q;
  assign lap_e_s   = bus.btn_lap_i   & ~btn_lap_q;
  assign clear_e_s = bus.btn_clear_i & ~btn_clear_q;

  assign full_s    = (count_q == CW'(LAP_DEPTH));
  assign push_s    = lap_e_s & ((state_q == S_RUN) | (state_q == S_PAUSE)) & ~clear_e_s;
  assign pop_s     = bus.lap_rd_i & (count_q != CW'(0)) & ~clear_e_s;
  assign do_push_s = push_s & (~full_s | pop_s);

  // Next-state: clear beats load beats start edge beats tick.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    dec_s      = bcd_dec(time_q);
    dir_d      = (state_q != S_RUN) ? bus.mode_down_i : dir_q;
    if (clear_e_s) begin
      state_d    = S_IDLE;
      time_d     = 24'h000000;
      overflow_d = 1'b0;
      drop_d     = 1'b0;
    end else if (bus.load_en_i && state_q != S_RUN) begin
      state_d    = S_IDLE;
      time_d     = clamp_load(bus.load_time_i);
      overflow_d = 1'b0;
    end else if (start_e_s) begin
      case (state_q)
        S_IDLE:  state_d = (bus.mode_down_i && time_q == 24'h000000) ? S_IDLE : S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_DONE;
      endcase
    end else if (bus.tick_i && state_q == S_RUN) begin
      if (dir_q) begin
        if (time_q == 24'h000000) state_d = S_DONE;
        else begin
          time_d  = dec_s;
          state_d = (dec_s == 24'h000000) ? S_DONE : S_RUN;
        end
      end else if (time_q == TOP) begin
        if (WRAP != 0) time_d = 24'h000000;
        else overflow_d = 1'b1;
      end else begin
        time_d = bcd_inc(time_q);
      end
    end else begin
      state_d = state_q;
    end
    if (push_s && full_s && !pop_s) drop_d = 1'b1;
    else drop_d = drop_d;
    case ({do_push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_q      <= 24'h000000;
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
      dir_q       <= 1'b0;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      btn_start_q <= 1'b0;
      btn_lap_q   <= 1'b0;
      btn_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      dir_q       <= dir_d;
      running_q   <= (state_d == S_RUN);
      expired_q   <= (state_d == S_DONE);
      btn_start_q <= bus.btn_start_i;
      btn_lap_q   <= bus.btn_lap_i;
      btn_clear_q <= bus.btn_clear_i;
    end
  end

  // Lap storage: circular buffer, pushed entry is the time before this cycle's tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAP_DEPTH; i++) fifo_q[i] <= 24'h000000;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_e_s) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        fifo_q[wr_ptr_q] <= time_q;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign bus.time_bcd_o  = time_q;
  assign bus.running_o   = running_q;
  assign bus.expired_o   = expired_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.lap_valid_o = (count_q != CW'(0));
  assign bus.lap_data_o  = fifo_q[rd_ptr_q];
  assign bus.lap_count_o = count_q;
  assign bus.lap_drop_o  = drop_q;

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised BCD stopwatch and countdown timer (mm:ss.cc), successor to the fixed six-digit stopwatch. Adds an explicit run/pause/done FSM, up/down mode, preset load, saturate-or-wrap at the top count, and a lap FIFO readable by the display/UART side. Sits between the button debouncers/centisecond tick generator and the seven-segment/display mux.

Parameters:
LAP_DEPTH, 4, lap FIFO entries (power of 2, 2..16)
MIN_MAX, 59, highest minute value (BCD-representable, 1..99)
WRAP, 0, count-up at top: 0 = saturate and flag, 1 = wrap to 00:00.00

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-low
tick  in  1  one-clk pulse per 10 ms (count enable)
btn_start  in  1  debounced level; rising edge toggles run/pause
btn_lap  in  1  debounced level; rising edge pushes current time to lap FIFO
btn_clear  in  1  debounced level; rising edge clears time and FIFO
mode_down  in  1  1 = countdown, 0 = count-up; sampled only when not RUN
load_en  in  1  one-clk load of load_time; honoured only when not RUN
load_time  in  24  {min1,min0,sec1,sec0,cs1,cs0} BCD preset
time_bcd  out  24  current time, same packing as load_time
running  out  1  state == RUN
expired  out  1  state == DONE (countdown reached zero)
overflow  out  1  sticky: count-up hit top with WRAP=0
lap_rd  in  1  pop request
lap_valid  out  1  FIFO not empty
lap_data  out  24  head entry (valid when lap_valid)
lap_count  out  clog2(LAP_DEPTH)+1  entries held
lap_drop  out  1  sticky: push attempted while full

Behaviour:
- Reset (rst=0, async): time_bcd=0, state IDLE, running=0, expired=0, overflow=0, FIFO empty, lap_count=0, lap_drop=0, edge-detect registers=0.
- Button edges: each btn_* registered on clk; edge = btn & ~btn_q. Acts in the cycle the edge is detected; one action per press.
- States: IDLE (zero/preset, not counting), RUN, PAUSE, DONE.
  IDLE --start edge--> RUN, except mode_down with time==0 stays IDLE.
  RUN --start edge--> PAUSE; PAUSE --start edge--> RUN.
  RUN --countdown reaches 00:00.00--> DONE; DONE --start edge--> stays DONE.
  Any state --clear edge--> IDLE.
- Priority in one cycle: clear > load_en > start edge > tick.
- Counting only in RUN, one step per tick. Up: cs0 0-9, cs1 0-9, sec0 0-9, sec1 0-5, min 00..MIN_MAX, carries ripple within the same cycle (no extra latency); time_bcd updates the cycle after tick.
- Top (MIN_MAX:59.99) + tick: WRAP=0 -> hold, set overflow, remain RUN; WRAP=1 -> 00:00.00, overflow unchanged.
- Down: borrow chain mirrors up; transition to 00:00.00 enters DONE in same update, expired=1 next cycle; never underflows.
- Start edge coincident with tick: state changes, tick for that cycle is not applied.
- load_en in IDLE/PAUSE/DONE: time_bcd <= load_time, state IDLE, expired=0, overflow=0. Invalid BCD digits (>9, or sec1>5, or minutes>MIN_MAX) clamp that field to its max. Ignored in RUN.
- Clear: time 0, FIFO flushed, overflow/lap_drop/expired cleared.
- Lap: push of pre-tick time_bcd on lap edge in RUN or PAUSE; ignored in IDLE/DONE. Full and no pop -> entry dropped, lap_drop set. Full with simultaneous pop -> both succeed, count unchanged.
- lap_rd when empty: ignored. lap_data is show-ahead (head visible with lap_valid, no read latency); pop advances head next cycle.
- mode_down change during RUN ignored until next non-RUN state.

Test Plan:
- Reset, start edge, 250 ticks -> time_bcd 00:02.50, running=1; start edge -> PAUSE, 10 further ticks leave 00:02.50.
- MIN_MAX=59, WRAP=0: load 59:59.98, start, 3 ticks -> 59:59.99 held, overflow=1; repeat with WRAP=1 -> 00:00.01, overflow=0.
- mode_down=1, load 00:01.00, start, 100 ticks -> 00:00.00, expired=1, running=0; 5 more ticks and a start edge -> unchanged.
- LAP_DEPTH=4: 5 lap edges at distinct times in RUN -> lap_count=4, lap_drop=1, pops return first four times in order, then lap_valid=0.
- Full FIFO, lap edge and lap_rd same cycle -> count stays 4, oldest popped, newest appended; clear edge same cycle as start edge -> IDLE, time 0, FIFO empty.
- Assert rst low mid-RUN at 00:37.12 -> all outputs zero immediately (asynchronous), IDLE after release; load of 7A:65.3C in IDLE -> 59:59.39.
